ct_spsram_1024x128_ctrl: RTL
============================

Name: ct_spsram_1024x128_ctrl

Overview:
- Initiator-side controller for the 1024x128 single-port SRAM.
- Accepts read/write requests on a valid/ready channel and drives the SRAM's active-low CEN/GWEN/WEN port.
- Captures Q one cycle after each read and returns read data in order on a valid/ready response channel.
- Sits between a cache/buffer client and the SRAM wrapper; owns the credit-based response buffering so the SRAM is never read without buffer space.

Parameters:
- ADDR_WIDTH, 10, SRAM address width (depth = 2^ADDR_WIDTH).
- DATA_WIDTH, 128, data and bit-write-enable width.
- RSP_DEPTH, 2, response FIFO entries; legal values >= 2.
- INIT_VALUE, {DATA_WIDTH{1'b0}}, pattern written by the optional init sweep.

Ports:
- CLK  in  1  clock; SRAM samples on the same edge.
- RST  in  1  synchronous reset, active-high.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH  active-high per-bit write enable.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  consumer ready.
- rsp_rdata  out  DATA_WIDTH  read data.
- busy  out  1  init sweep in progress.
- sram_A  out  ADDR_WIDTH  to SRAM A.
- sram_CEN  out  1  to SRAM CEN, active-low.
- sram_GWEN  out  1  to SRAM GWEN, active-low, 0 = write.
- sram_WEN  out  DATA_WIDTH  to SRAM WEN, active-low per bit.
- sram_D  out  DATA_WIDTH  to SRAM D.
- sram_Q  in  DATA_WIDTH  from SRAM Q.

Behaviour:
- Clocking and reset: one clock CLK; reset RST is synchronous, active-high.
- States: RUN, plus INIT when the optional feature is enabled. Reset enters INIT (feature on) or RUN (feature off).
- Fire: req_fire = req_vld & req_rdy.
- SRAM drive, combinational from the fire:
  - sram_CEN = ~req_fire.
  - sram_GWEN = ~(req_fire & req_wr).
  - sram_WEN = req_wr ? ~req_wmask : all-ones.
  - sram_A = req_addr.
  - sram_D = req_wdata.
- Idle SRAM values (no fire, or RST high): CEN=1, GWEN=1, WEN all-ones, A=0, D=0.
- Credits:
  - cnt = FIFO occupancy + in-flight read (0..RSP_DEPTH).
  - Read fire increments cnt; rsp fire (rsp_vld & rsp_rdy) decrements it; both in the same cycle leave it unchanged.
- Ready: req_rdy = RUN & ~RST & (cnt < RSP_DEPTH | rsp fire). Writes are gated the same way, so ordering stays strict.
- Read latency:
  - Read fired in cycle N: sram_Q is sampled at the end of cycle N+1 and pushed to the FIFO.
  - rsp_vld is high in cycle N+2 at the earliest.
  - Sustained 1 read/cycle with rsp_rdy held high.
- Writes produce no response.
- Read-after-write to the same address returns the new data; the SRAM orders them naturally.
- Response channel:
  - In-order FIFO; rsp_rdata stable while rsp_vld & ~rsp_rdy.
  - Push and pop in the same cycle are legal when the FIFO is full, because the credit reservation guarantees space.
- FIFO pointers wrap modulo RSP_DEPTH.
- Reset values: rsp_vld=0, rsp_rdata=0, req_rdy=0, busy = 1 if feature on else 0.
- RST mid-operation drops the in-flight read and all FIFO contents; cnt=0.

Optional Feature:
- Macro: CT_SPSRAM_CTRL_INIT_EN.
- Defined:
  - After reset, INIT state writes INIT_VALUE to addresses 0..2^ADDR_WIDTH-1, one per cycle.
  - Drive during sweep: CEN=0, GWEN=0, WEN all-zero, A = sweep counter.
  - busy=1 and req_rdy=0 throughout the sweep.
  - After the last address (1023) is written, the next cycle is RUN with busy=0.
  - RST during the sweep restarts it at address 0.
- Undefined: no INIT state, no sweep counter, busy tied 0, RUN directly after reset.

Test Plan:
- Reset held 3 cycles -> CEN=1, GWEN=1, WEN=all-ones, rsp_vld=0, req_rdy=0 during RST; req_rdy=1 in the first cycle after (feature off).
- Write addr 0x155, data 0xA5..A5, mask all-ones; then read 0x155 -> GWEN=0 and WEN=0 in the write cycle; rsp_rdata=0xA5..A5 two cycles after the read fire.
- Write 0xFFFF..FF to addr 7, then write 0x0 with mask 0x0000..00FF, then read -> rsp_rdata=0xFFFF..FF00.
- rsp_rdy=0, issue 4 reads -> req_rdy drops after 2 fires; FIFO holds 2 entries in order. Raise rsp_rdy -> remaining reads accepted; 4 responses returned in address order.
- rsp_rdy=1, 16 back-to-back reads -> req_rdy never drops; 16 consecutive rsp_vld cycles.
- With CT_SPSRAM_CTRL_INIT_EN: busy=1 for exactly 1024 cycles after reset; read of addr 0x3FF then returns INIT_VALUE. RST asserted at sweep cycle 500 -> sweep restarts at A=0.

Source files
------------

// File: rtl/ct_spsram_1024x128_ctrl.sv
// -----------------------------------------------------------------------------
// ct_spsram_1024x128_ctrl
//
// Initiator-side controller for a 1024x128 single-port SRAM. Read/write
// requests arrive on a valid/ready channel and are turned into the SRAM's
// active-low CEN/GWEN/WEN strobes in the cycle they are accepted. Read data
// comes back on sram_Q one cycle later, is captured into a small in-order
// response FIFO and returned on a valid/ready response channel.
//
// A credit counter covers FIFO occupancy plus the read still in flight, so a
// read is only issued when there is guaranteed room for its data. Writes are
// gated by the same credit check, which keeps request ordering strict.
//
// Optional feature (macro CT_SPSRAM_CTRL_INIT_EN): after reset an INIT state
// sweeps INIT_VALUE into every address, one per cycle, with busy high and
// req_rdy low. Without the macro there is no INIT state and busy is tied low.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   req_vld/req_rdy     request handshake
//   req_wr              1 = write, 0 = read
//   req_addr            word address
//   req_wdata/req_wmask write data and active-high per-bit write enable
//   rsp_vld/rsp_rdy     response handshake
//   rsp_rdata           read data, held stable while rsp_vld & ~rsp_rdy
//   busy                init sweep in progress
//   sram_A/CEN/GWEN/WEN/D  SRAM macro inputs (CEN, GWEN, WEN active-low)
//   sram_Q              SRAM macro output
// -----------------------------------------------------------------------------
module ct_spsram_1024x128_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 10,
    parameter int unsigned            DATA_WIDTH = 128,
    parameter int unsigned            RSP_DEPTH  = 2,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sram_A,
    output logic                  sram_CEN,
    output logic                  sram_GWEN,
    output logic [DATA_WIDTH-1:0] sram_WEN,
    output logic [DATA_WIDTH-1:0] sram_D,
    input  logic [DATA_WIDTH-1:0] sram_Q
);

    // Credit counter must hold 0..RSP_DEPTH inclusive.
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

    // Pointer advance with wrap at RSP_DEPTH (works for non-power-of-two depths).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Run/init state
    // ------------------------------------------------------------------
    logic run_s;
    logic sweep_wr_s;

`ifdef CT_SPSRAM_CTRL_INIT_EN
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   sweep_q;
    logic                    busy_q;

    // Init FSM: sweep every address once after reset, then hand over to RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            sweep_q <= {ADDR_WIDTH{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (sweep_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= ST_RUN;
                        sweep_q <= {ADDR_WIDTH{1'b0}};
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_INIT;
                        sweep_q <= sweep_q + ADDR_WIDTH'(1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                    sweep_q <= {ADDR_WIDTH{1'b0}};
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_INIT;
                    sweep_q <= {ADDR_WIDTH{1'b0}};
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    assign run_s      = (state_q == ST_RUN);
    assign sweep_wr_s = (state_q == ST_INIT) & ~RST;
    assign busy       = busy_q;
`else
    // INIT_VALUE only matters for the sweep; keep it referenced.
    logic unused_init_s;
    assign unused_init_s = ^INIT_VALUE;

    assign run_s      = 1'b1;
    assign sweep_wr_s = 1'b0;
    assign busy       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshakes and credits
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] fifo_cnt_q;
    logic [CNT_W-1:0] fifo_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic             rd_pend_q;
    logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];

    logic req_fire_s;
    logic rd_fire_s;
    logic rsp_fire_s;
    logic push_s;

    // rsp_vld is masked during RST so nothing can be popped from a FIFO that
    // is about to be flushed.
    assign rsp_vld    = (fifo_cnt_q != {CNT_W{1'b0}}) & ~RST;
    assign rsp_fire_s = rsp_vld & rsp_rdy;

    // A pop in the same cycle frees a credit, which keeps a full pipeline
    // streaming at one read per cycle.
    assign req_rdy    = run_s & ~RST & ((cnt_q < CNT_MAX) | rsp_fire_s);
    assign req_fire_s = req_vld & req_rdy;
    assign rd_fire_s  = req_fire_s & ~req_wr;

    // The read issued last cycle has its data on sram_Q now.
    assign push_s     = rd_pend_q;

    assign rsp_rdata  = fifo_mem_q[rd_ptr_q];

    // Next-state for the credit counter, FIFO occupancy and pointers.
    always_comb begin
        if (rd_fire_s & ~rsp_fire_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (~rd_fire_s & rsp_fire_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (push_s & ~rsp_fire_s) begin
            fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        end else if (~push_s & rsp_fire_s) begin
            fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
        end else begin
            fifo_cnt_d = fifo_cnt_q;
        end

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rsp_fire_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Credit, in-flight and pointer registers; reset drops any pending read.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= {CNT_W{1'b0}};
            fifo_cnt_q <= {CNT_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            rd_pend_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_pend_q  <= rd_fire_s;
        end
    end

    // Response storage; cleared on reset so rsp_rdata starts at zero.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                fifo_mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= sram_Q;
        end
    end

    // ------------------------------------------------------------------
    // SRAM drive: request fire has priority, then the init sweep, else idle.
    // ------------------------------------------------------------------
    // SRAM port mux.
    always_comb begin
        if (req_fire_s) begin
            sram_CEN  = 1'b0;
            sram_GWEN = ~req_wr;
            sram_WEN  = req_wr ? ~req_wmask : {DATA_WIDTH{1'b1}};
            sram_A    = req_addr;
            sram_D    = req_wdata;
        end else if (sweep_wr_s) begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
            sram_CEN  = 1'b0;
            sram_GWEN = 1'b0;
            sram_WEN  = {DATA_WIDTH{1'b0}};
            sram_A    = sweep_q;
            sram_D    = INIT_VALUE;
`else
            sram_CEN  = 1'b1;
            sram_GWEN = 1'b1;
            sram_WEN  = {DATA_WIDTH{1'b1}};
            sram_A    = {ADDR_WIDTH{1'b0}};
            sram_D    = {DATA_WIDTH{1'b0}};
`endif
        end else begin
            sram_CEN  = 1'b1;
            sram_GWEN = 1'b1;
            sram_WEN  = {DATA_WIDTH{1'b1}};
            sram_A    = {ADDR_WIDTH{1'b0}};
            sram_D    = {DATA_WIDTH{1'b0}};
        end
    end

endmodule
